// File: rtl/cpu_controller_if.sv
// Handshake and datapath-control bundle between the sequencer and its
// surroundings (host preload stream, instruction memory, datapath).
interface cpu_controller_if #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 8
);
    logic                start;
    logic                init_valid;
    logic [WIDTH-1:0]    init_data;
    logic                init_ready;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [WIDTH-1:0]    imem_data;
    logic [WIDTH-1:0]    ir_input;
    logic [WIDTH-1:0]    data_input;
    logic                wEn;
    logic                registerFileSelect;
    logic [PC_WIDTH-1:0] pc;
    logic                busy;
    logic                halted;

    // Controller side
    modport master (
        input  start, init_valid, init_data, imem_valid, imem_data,
        output init_ready, imem_req, imem_addr, ir_input, data_input,
               wEn, registerFileSelect, pc, busy, halted
    );

    // Host / memory / datapath side
    modport slave (
        output start, init_valid, init_data, imem_valid, imem_data,
        input  init_ready, imem_req, imem_addr, ir_input, data_input,
               wEn, registerFileSelect, pc, busy, halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle sequencer for the RISC datapath: register-file preload from a
// host stream, then fetch/decode/execute/writeback until a HALT opcode.
// Every output is a flop; each transition loads the values for the state
// being entered.
module cpu_controller #(
    parameter int WIDTH         = 32,
    parameter int PC_WIDTH      = 8,
    parameter int NUM_INIT_REGS = 32
) (
    input logic              clk,
    input logic              reset,
    cpu_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_INIT_SETUP, S_INIT_WRITE, S_FETCH,
        S_WAIT_MEM, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_INIT_REGS - 1);
    localparam logic [5:0] HALT_OP  = 6'h3F;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [5:0]          idx_q;
    logic [WIDTH-1:0]    ir_input_q;
    logic [WIDTH-1:0]    data_input_q;
    logic                wEn_q;
    logic                rfs_q;
    logic                imem_req_q;
    logic                init_ready_q;
    logic                busy_q;
    logic                halted_q;

    logic [WIDTH-1:0]    init_ir;
    logic [5:0]          fetched_op;

    // Preload IR word: only the rd field carries the target register index
    always_comb begin
        init_ir        = '0;
        init_ir[15:11] = idx_q[4:0];
    end

    assign fetched_op = bus.imem_data[WIDTH-1 -: 6];

    // Sequencer FSM with registered outputs; wEn is a one-cycle strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            idx_q        <= '0;
            ir_input_q   <= '0;
            data_input_q <= '0;
            wEn_q        <= 1'b0;
            rfs_q        <= 1'b0;
            imem_req_q   <= 1'b0;
            init_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            wEn_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_q   <= '0;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (NUM_INIT_REGS == 0) begin
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end else begin
                            state_q      <= S_INIT;
                            init_ready_q <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    // init_ready is high throughout INIT, so valid alone completes the handshake
                    if (bus.init_valid) begin
                        data_input_q <= bus.init_data;
                        ir_input_q   <= init_ir;
                        init_ready_q <= 1'b0;
                        rfs_q        <= 1'b1;
                        state_q      <= S_INIT_SETUP;
                    end
                end
                S_INIT_SETUP: begin
                    wEn_q   <= 1'b1;
                    state_q <= S_INIT_WRITE;
                end
                S_INIT_WRITE: begin
                    idx_q <= idx_q + 6'd1;
                    rfs_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end else begin
                        state_q      <= S_INIT;
                        init_ready_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    if (bus.imem_valid) begin
                        ir_input_q <= bus.imem_data;
                        imem_req_q <= 1'b0;
                        if (fetched_op == HALT_OP) begin
                            state_q  <= S_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    wEn_q   <= 1'b1;
                    state_q <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    // pc advances as the write completes, so the next fetch sees it
                    pc_q       <= pc_q + PC_WIDTH'(1);
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pc                 = pc_q;
    assign bus.imem_addr          = pc_q;
    assign bus.imem_req           = imem_req_q;
    assign bus.init_ready         = init_ready_q;
    assign bus.ir_input           = ir_input_q;
    assign bus.data_input         = data_input_q;
    assign bus.wEn                = wEn_q;
    assign bus.registerFileSelect = rfs_q;
    assign bus.busy               = busy_q;
    assign bus.halted             = halted_q;

endmodule
